// File: rtl/riscv_pkg.sv
// Shared pipeline definitions used by the writeback stage.
//   XLEN            datapath width
//   REG_ADDR_WIDTH  register index width
//   REG_ZERO        hard-wired zero register index (x0)
//   STARVE_CNT_W    width of the MEM starvation counter (holds up to 15)
//   wb_src_e        identifies which producer owns the writeback port
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: owns the single register-file write port and picks at
// most one result per cycle from the ALU (single-cycle) and MEM (load /
// multicycle) producers. The winning result is registered for exactly one
// cycle; the registered port doubles as the bypass source for decode because
// the register-file read is not write-through.
//
// Ports
//   clock, reset                  rising-edge clock, async active-high reset
//   alu_valid/alu_rd/alu_data     ALU result offer
//   alu_ready                     ALU result accepted this cycle
//   mem_valid/mem_rd/mem_data     MEM result offer
//   mem_ready                     MEM result accepted this cycle
//   register_write                write enable (registered, one cycle)
//   write_register, write_data    write index / data (registered, hold)
//   starve_active                 MEM currently holds forced priority
//
// Handshake: a result transfers on a rising edge where valid & ready. ready
// is a combinational function of valid and the starvation counter only (never
// of the outputs), is raised only for the single winner, and a producer keeps
// valid/rd/data stable until it is accepted.
module writeback_arbiter
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = XLEN,
  parameter int REG_ADDR_WIDTH = riscv_pkg::REG_ADDR_WIDTH,
  parameter int STARVE_LIMIT   = 4            // legal range 1..15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  output logic                      register_write,
  output logic [REG_ADDR_WIDTH-1:0] write_register,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic                      starve_active
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_C = '0;

  logic [STARVE_CNT_W-1:0]   starve_cnt;
  logic [STARVE_CNT_W-1:0]   starve_cnt_next;
  logic                      grant_valid;
  wb_src_e                   grant_src;
  logic [REG_ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0]     sel_data;

  // The counter saturates at the limit, so equality is the forced-priority
  // condition.
  assign starve_active = (starve_cnt == LIMIT_C);

  // Priority: a starved MEM beats the ALU; otherwise the ALU wins and MEM
  // only gets the port when the ALU is idle.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = WB_ALU;
    if (starve_active && mem_valid) begin
      grant_valid = 1'b1;
      grant_src   = WB_MEM;
    end else if (alu_valid) begin
      grant_valid = 1'b1;
      grant_src   = WB_ALU;
    end else if (mem_valid) begin
      grant_valid = 1'b1;
      grant_src   = WB_MEM;
    end
  end

  assign alu_ready = grant_valid && (grant_src == WB_ALU);
  assign mem_ready = grant_valid && (grant_src == WB_MEM);

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (grant_src == WB_MEM) begin
      sel_rd   = mem_rd;
      sel_data = mem_data;
    end
  end

  // The counter measures how long the current MEM result has been waiting;
  // it restarts whenever there is no MEM result or the current one is taken.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!mem_valid || mem_ready) begin
      starve_cnt_next = '0;
    end else if (starve_cnt != LIMIT_C) begin
      starve_cnt_next = starve_cnt + 1'b1;
    end
  end

  // Output stage. Writes to x0 still load index/data (keeps the bypass view
  // consistent) but never raise the write enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt     <= '0;
      register_write <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else begin
      starve_cnt     <= starve_cnt_next;
      register_write <= grant_valid && (sel_rd != ZERO_C);
      if (grant_valid) begin
        write_register <= sel_rd;
        write_data     <= sel_data;
      end
    end
  end

  // Producer-side protocol and arbiter invariants.
  a_one_winner : assert property (@(posedge clock) disable iff (reset)
    !(alu_ready && mem_ready));

  a_alu_hold : assert property (@(posedge clock) disable iff (reset)
    (alu_valid && !alu_ready) |=> (alu_valid && $stable(alu_rd) && $stable(alu_data)));

  a_mem_hold : assert property (@(posedge clock) disable iff (reset)
    (mem_valid && !mem_ready) |=> (mem_valid && $stable(mem_rd) && $stable(mem_data)));

endmodule

// File: tb/tb_writeback_arbiter.sv
`timescale 1ns/1ps
module tb_writeback_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;
  localparam int EW    = 1 + AW + DW;

  logic          clock;
  logic          reset;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          register_write;
  logic [AW-1:0] write_register;
  logic [DW-1:0] write_data;
  logic          starve_active;

  int checks = 0;
  int errors = 0;

  // Expected write-port contents for the following cycle: {we, rd, data}.
  logic [EW-1:0] exp_q[$];

  writeback_arbiter #(
    .DATA_WIDTH(DW),
    .REG_ADDR_WIDTH(AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_rd(mem_rd),
    .mem_data(mem_data),
    .register_write(register_write),
    .write_register(write_register),
    .write_data(write_data),
    .starve_active(starve_active)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Driver tasks (inputs change on the falling edge)
  task automatic drive_alu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_mem(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    mem_valid = v;
    mem_rd    = rd;
    mem_data  = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_alu(1'b0, '0, '0);
    drive_mem(1'b0, '0, '0);
    #3;
    checks++;
    if (register_write !== 1'b0 || write_register !== '0 || write_data !== '0 || starve_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: we=%b rd=%0d data=%h starve=%b, want 0 0 0 0",
               register_write, write_register, write_data, starve_active);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_alu_only();
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL alu_only_ready: alu_ready=%b mem_ready=%b, want 1 0", alu_ready, mem_ready);
    end
    @(negedge clock);
    drive_alu(1'b0, '0, '0);
    checks++;
    if (register_write !== 1'b1 || write_register !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_only_write: we=%b rd=%0d data=%h, want 1 5 deadbeef",
               register_write, write_register, write_data);
    end
    @(negedge clock);
    checks++;
    if (register_write !== 1'b0 || write_register !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_only_idle_hold: we=%b rd=%0d data=%h, want 0 5 deadbeef",
               register_write, write_register, write_data);
    end
  endtask

  task automatic test_both_once();
    drive_alu(1'b1, 5'd3, 32'd1);
    drive_mem(1'b1, 5'd7, 32'd2);
    #1;
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL both_first_grant: alu_ready=%b mem_ready=%b, want 1 0", alu_ready, mem_ready);
    end
    @(negedge clock);
    checks++;
    if (register_write !== 1'b1 || write_register !== 5'd3 || write_data !== 32'd1) begin
      errors++;
      $display("FAIL both_first_write: we=%b rd=%0d data=%h, want 1 3 1",
               register_write, write_register, write_data);
    end
    drive_alu(1'b0, '0, '0);
    #1;
    checks++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL both_second_grant: mem_ready=%b alu_ready=%b, want 1 0", mem_ready, alu_ready);
    end
    @(negedge clock);
    checks++;
    if (register_write !== 1'b1 || write_register !== 5'd7 || write_data !== 32'd2) begin
      errors++;
      $display("FAIL both_second_write: we=%b rd=%0d data=%h, want 1 7 2",
               register_write, write_register, write_data);
    end
    drive_mem(1'b0, '0, '0);
    @(negedge clock);
  endtask

  task automatic test_starvation();
    drive_mem(1'b1, 5'd12, 32'h77);
    drive_alu(1'b1, 5'd1, 32'd200);
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (k < 4) begin
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0 || starve_active !== 1'b0) begin
          errors++;
          $display("FAIL starve_cycle%0d: alu_ready=%b mem_ready=%b starve=%b, want 1 0 0",
                   k, alu_ready, mem_ready, starve_active);
        end
      end else if (k == 4) begin
        if (alu_ready !== 1'b0 || mem_ready !== 1'b1 || starve_active !== 1'b1) begin
          errors++;
          $display("FAIL starve_cycle4: alu_ready=%b mem_ready=%b starve=%b, want 0 1 1",
                   alu_ready, mem_ready, starve_active);
        end
      end else begin
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0 || starve_active !== 1'b0) begin
          errors++;
          $display("FAIL starve_cycle5: alu_ready=%b mem_ready=%b starve=%b, want 1 0 0",
                   alu_ready, mem_ready, starve_active);
        end
      end
      @(negedge clock);
      if (k == 4) begin
        checks++;
        if (register_write !== 1'b1 || write_register !== 5'd12 || write_data !== 32'h77) begin
          errors++;
          $display("FAIL starve_mem_write: we=%b rd=%0d data=%h, want 1 12 77",
                   register_write, write_register, write_data);
        end
        drive_mem(1'b1, 5'd13, 32'h88);
      end else if (k == 5) begin
        drive_alu(1'b0, '0, '0);
      end else begin
        drive_alu(1'b1, 5'(k + 2), 32'(201 + k));
      end
    end
    @(negedge clock);
    drive_mem(1'b0, '0, '0);
    @(negedge clock);
  endtask

  task automatic test_x0();
    drive_alu(1'b1, 5'd0, 32'h12345678);
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready: alu_ready=%b, want 1", alu_ready);
    end
    @(negedge clock);
    drive_alu(1'b0, '0, '0);
    checks++;
    if (register_write !== 1'b0 || write_register !== 5'd0 || write_data !== 32'h12345678) begin
      errors++;
      $display("FAIL x0_write: we=%b rd=%0d data=%h, want 0 0 12345678",
               register_write, write_register, write_data);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    drive_alu(1'b1, 5'd4, 32'h44);
    drive_mem(1'b1, 5'd9, 32'hAA);
    @(negedge clock);
    drive_alu(1'b1, 5'd6, 32'h66);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (register_write !== 1'b0 || write_register !== '0 || write_data !== '0 || starve_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: we=%b rd=%0d data=%h starve=%b, want 0 0 0 0",
               register_write, write_register, write_data, starve_active);
    end
    @(negedge clock);
    drive_alu(1'b0, '0, '0);
    drive_mem(1'b0, '0, '0);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (register_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dropped: we=%b, want 0", register_write);
    end
    // A cleared counter means MEM must wait the full limit again.
    drive_alu(1'b1, 5'd20, 32'd0);
    drive_mem(1'b1, 5'd21, 32'hBB);
    for (int k = 0; k <= LIMIT; k++) begin
      #1;
      checks++;
      if (k < LIMIT) begin
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_restart%0d: alu_ready=%b mem_ready=%b, want 1 0", k, alu_ready, mem_ready);
        end
      end else begin
        if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
          errors++;
          $display("FAIL reset_mid_restart%0d: alu_ready=%b mem_ready=%b, want 0 1", k, alu_ready, mem_ready);
        end
      end
      @(negedge clock);
      if (k < LIMIT) drive_alu(1'b1, 5'(21 + k), 32'(k + 1));
    end
    drive_mem(1'b0, '0, '0);
    @(negedge clock);
    drive_alu(1'b0, '0, '0);
    @(negedge clock);
  endtask

  // Randomized traffic against a model that reasons about how long the
  // current MEM result has been waiting, not about the arbiter's registers.
  task automatic test_random();
    logic          a_pend, m_pend;
    logic [AW-1:0] a_rd_m, m_rd_m, last_rd;
    logic [DW-1:0] a_data_m, m_data_m, last_data;
    int            m_waited;
    logic          alu_win, mem_win;
    logic [EW-1:0] e;

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    a_pend = 1'b0; m_pend = 1'b0; m_waited = 0;
    a_rd_m = '0; m_rd_m = '0; a_data_m = '0; m_data_m = '0;
    last_rd = '0; last_data = '0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (register_write !== e[EW-1] || write_register !== e[DW +: AW] || write_data !== e[DW-1:0]) begin
          errors++;
          $display("FAIL random_write cyc%0d: we=%b rd=%0d data=%h, want %b %0d %h",
                   cyc, register_write, write_register, write_data, e[EW-1], e[DW +: AW], e[DW-1:0]);
        end
      end
      if (!a_pend && $urandom_range(0, 99) < 60) begin
        a_pend = 1'b1;
        a_rd_m = AW'($urandom_range(0, 31));
        a_data_m = $urandom;
      end
      if (!m_pend && $urandom_range(0, 99) < 45) begin
        m_pend = 1'b1;
        m_rd_m = AW'($urandom_range(0, 31));
        m_data_m = $urandom;
        m_waited = 0;
      end
      drive_alu(a_pend, a_rd_m, a_data_m);
      drive_mem(m_pend, m_rd_m, m_data_m);
      #1;
      mem_win = m_pend && (m_waited >= LIMIT || !a_pend);
      alu_win = a_pend && !mem_win;
      checks++;
      if (alu_ready !== alu_win || mem_ready !== mem_win || starve_active !== (m_pend && m_waited >= LIMIT)) begin
        errors++;
        $display("FAIL random_grant cyc%0d: alu_ready=%b mem_ready=%b starve=%b, want %b %b %b",
                 cyc, alu_ready, mem_ready, starve_active, alu_win, mem_win, (m_pend && m_waited >= LIMIT));
      end
      if (alu_win) begin
        last_rd = a_rd_m; last_data = a_data_m;
        exp_q.push_back({(a_rd_m != 5'd0), a_rd_m, a_data_m});
        a_pend = 1'b0;
      end else if (mem_win) begin
        last_rd = m_rd_m; last_data = m_data_m;
        exp_q.push_back({(m_rd_m != 5'd0), m_rd_m, m_data_m});
      end else begin
        exp_q.push_back({1'b0, last_rd, last_data});
      end
      if (mem_win) m_pend = 1'b0;
      else if (m_pend) m_waited++;
      @(negedge clock);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (register_write !== e[EW-1] || write_register !== e[DW +: AW] || write_data !== e[DW-1:0]) begin
        errors++;
        $display("FAIL random_write_last: we=%b rd=%0d data=%h, want %b %0d %h",
                 register_write, write_register, write_data, e[EW-1], e[DW +: AW], e[DW-1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_both_once();
    test_starvation();
    test_x0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
